// File: rtl/grad_pkg.sv
// rtl/grad_pkg.sv - shared constants, FSM encoding and helpers for the gradient squarer
// Purpose : widths, state encoding and the absolute-value helper used by
//           grad_sqr and its per-channel shift-add datapath.
// Ports   : none (package).
package grad_pkg;

    localparam int IN_W  = 9;
    localparam int OUT_W = 2 * IN_W - 1;
    localparam int CNT_W = $clog2(IN_W);

    // Index of the last multiplier bit; the final add happens on this count.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ABS  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Magnitude of a two's-complement value, returned unsigned in the same
    // width. The most negative input maps to 2^(IN_W-1), which still fits
    // because the result is read as unsigned, so no saturation is needed.
    function automatic logic [IN_W-1:0] abs_val(input logic [IN_W-1:0] v);
        return v[IN_W-1] ? (~v + IN_W'(1)) : v;
    endfunction

endpackage

// File: rtl/shift_add_sqr.sv
// rtl/shift_add_sqr.sv - one squaring channel: operand register plus shift-add accumulator
// Purpose : holds |value| and accumulates |value|^2 one multiplier bit per step.
// Ports   : clk, rst    - clock, async active-high reset
//           load        - capture |value| and clear the accumulator
//           step        - perform the add for multiplier bit cnt
//           cnt         - current multiplier bit index (shared counter)
//           value       - signed input operand
//           acc_next    - accumulator value after the current step
module shift_add_sqr
    import grad_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [CNT_W-1:0] cnt,
    input  logic [IN_W-1:0]  value,
    output logic [OUT_W-1:0] acc_next
);

    logic [IN_W-1:0]  opnd;
    logic [OUT_W-1:0] acc;
    logic [IN_W-1:0]  mbits;

    // acc_next is exported so the top can register the final square on the
    // same edge that performs the last add, instead of waiting a cycle.
    always_comb begin
        mbits    = opnd >> cnt;
        acc_next = acc;
        if (mbits[0]) begin
            acc_next = acc + (OUT_W'(opnd) << cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd <= '0;
            acc  <= '0;
        end else if (load) begin
            opnd <= abs_val(value);
            acc  <= '0;
        end else if (step) begin
            acc  <= acc_next;
        end
    end

endmodule

// File: rtl/grad_sqr.sv
// rtl/grad_sqr.sv - iterative squarer producing gx^2 and gy^2 for the magnitude stage
// Purpose : accepts a signed Sobel gradient pair, squares both components in
//           parallel with shift-add datapaths and holds the results until taken.
// Ports   : clk, rst             - clock, async active-high reset
//           in_valid, in_ready   - input handshake
//           gx, gy               - signed gradient components
//           out_valid, out_ready - output handshake
//           sqrx, sqry           - unsigned squares, kept after the handshake
//           busy                 - high whenever the FSM is not idle
module grad_sqr
    import grad_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  gx,
    input  logic [IN_W-1:0]  gy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] sqrx,
    output logic [OUT_W-1:0] sqry,
    output logic             busy
);

    state_t           state;
    logic [IN_W-1:0]  gx_r;
    logic [IN_W-1:0]  gy_r;
    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] x_acc_next;
    logic [OUT_W-1:0] y_acc_next;
    logic             load;
    logic             step;

    assign load = (state == ABS);
    assign step = (state == MUL);

    shift_add_sqr u_sqr_x (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .cnt      (cnt),
        .value    (gx_r),
        .acc_next (x_acc_next)
    );

    shift_add_sqr u_sqr_y (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .cnt      (cnt),
        .value    (gy_r),
        .acc_next (y_acc_next)
    );

    // in_ready, busy and out_valid are registered alongside the state so that
    // no output depends combinationally on any input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gx_r      <= '0;
            gy_r      <= '0;
            cnt       <= '0;
            sqrx      <= '0;
            sqry      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        gx_r     <= gx;
                        gy_r     <= gy;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ABS;
                    end
                end
                ABS: begin
                    cnt   <= '0;
                    state <= MUL;
                end
                MUL: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        sqrx      <= x_acc_next;
                        sqry      <= y_acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // A pending in_valid here is deliberately not looked at:
                    // the new pair is taken on the following IDLE cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grad_sqr.sv
// tb/tb_grad_sqr.sv - self-checking bench for grad_sqr
module tb_grad_sqr;

    localparam int IN_W  = 9;
    localparam int OUT_W = 17;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  gx;
    logic [IN_W-1:0]  gy;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] sqrx;
    logic [OUT_W-1:0] sqry;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_res = 0;
    int exp_acc = 0;
    int exp_res = 0;

    typedef struct {
        int          x;
        int          y;
        int          stall;
        logic [31:0] ex;
        logic [31:0] ey;
    } vec_t;

    vec_t vt[6];

    grad_sqr dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gx        (gx),
        .gy        (gy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sqrx      (sqrx),
        .sqry      (sqry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the square of a signed integer, computed directly.
    function automatic logic [31:0] ref_sq(input int v);
        return 32'(v * v);
    endfunction

    // Handshake bookkeeping on the active edge, where inputs are stable.
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) n_acc++;
        if (!rst && out_valid && out_ready) n_res++;
    end

    always @(negedge clk) begin
        if (!rst && in_ready && out_valid) check("ready_valid_exclusive", 1, 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full transaction. pulse_at injects a stray in_valid (gx=7) during
    // that busy cycle; overlap presents the next pair during the DONE handshake.
    task automatic do_txn(input int vx, input int vy, input int stall, input int pulse_at,
                          input logic [31:0] ex, input logic [31:0] ey,
                          input bit overlap, input int nx, input int ny, input string tag);
        int cyc;
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " in_ready_before"}, 32'(in_ready), 1);
        gx        = IN_W'(vx);
        gy        = IN_W'(vy);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        exp_acc++;
        @(negedge clk);
        in_valid = 1'b0;
        gx       = IN_W'($urandom);
        gy       = IN_W'($urandom);
        cyc      = 1;
        while (!out_valid && cyc < 40) begin
            if (cyc == 5) begin
                check({tag, " busy_mid"}, 32'(busy), 1);
                check({tag, " in_ready_mid"}, 32'(in_ready), 0);
            end
            if (cyc == pulse_at) begin
                in_valid = 1'b1;
                gx       = IN_W'(7);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 32'(cyc), 11);
        check({tag, " sqrx"}, 32'(sqrx), ex);
        check({tag, " sqry"}, 32'(sqry), ey);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check({tag, " hold_valid"}, {30'd0, out_valid, in_ready}, 32'b10);
            check({tag, " hold_data"}, 32'(sqrx) + 32'(sqry), ex + ey);
        end
        out_ready = 1'b1;
        if (overlap) begin
            in_valid = 1'b1;
            gx       = IN_W'(nx);
            gy       = IN_W'(ny);
        end
        @(negedge clk);
        exp_res++;
        check({tag, " out_valid_drop"}, 32'(out_valid), 0);
        check({tag, " in_ready_after"}, 32'(in_ready), 1);
        check({tag, " kept_sqrx"}, 32'(sqrx), ex);
    endtask

    initial begin
        int vx;
        int vy;
        int st;

        vt[0] = '{x: 3,    y: -4,   stall: 0, ex: 32'd9,     ey: 32'd16};
        vt[1] = '{x: -256, y: 255,  stall: 0, ex: 32'd65536, ey: 32'd65025};
        vt[2] = '{x: 0,    y: -1,   stall: 0, ex: 32'd0,     ey: 32'd1};
        vt[3] = '{x: 100,  y: -100, stall: 6, ex: 32'd10000, ey: 32'd10000};
        vt[4] = '{x: 255,  y: -256, stall: 2, ex: 32'd65025, ey: 32'd65536};
        vt[5] = '{x: 1,    y: 1,    stall: 1, ex: 32'd1,     ey: 32'd1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        gx        = '0;
        gy        = '0;
        #12;
        check("reset sqrx", 32'(sqrx), 0);
        check("reset sqry", 32'(sqry), 0);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset busy", 32'(busy), 0);
        check("reset in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_txn(vt[i].x, vt[i].y, vt[i].stall, 0, vt[i].ex, vt[i].ey, 1'b0, 0, 0, "vec");
        end

        // Stray in_valid during MUL must be ignored; 7 then accepted when re-presented.
        do_txn(20, -3, 0, 4, 32'd400, 32'd9, 1'b0, 0, 0, "busy_drop");
        repeat (3) begin
            @(negedge clk);
            check("busy_drop no_extra_result", 32'(out_valid), 0);
        end
        do_txn(7, 0, 0, 0, 32'd49, 32'd0, 1'b0, 0, 0, "late_seven");

        // Next pair offered during the DONE handshake: taken one cycle later.
        do_txn(-9, 11, 2, 0, 32'd81, 32'd121, 1'b1, 13, -14, "overlap");
        do_txn(13, -14, 0, 0, 32'd169, 32'd196, 1'b0, 0, 0, "overlap_next");

        // Async reset in the middle of MUL, between clock edges.
        gx        = IN_W'(-77);
        gy        = IN_W'(50);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        exp_acc++;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst out_valid", 32'(out_valid), 0);
        check("async_rst sqrx", 32'(sqrx), 0);
        check("async_rst sqry", 32'(sqry), 0);
        check("async_rst busy", 32'(busy), 0);
        check("async_rst in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        do_txn(-5, 12, 0, 0, 32'd25, 32'd144, 1'b0, 0, 0, "post_rst");

        for (int i = 0; i < 1000; i++) begin
            vx = int'($urandom_range(0, 511)) - 256;
            vy = int'($urandom_range(0, 511)) - 256;
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            do_txn(vx, vy, st, 0, ref_sq(vx), ref_sq(vy), 1'b0, 0, 0, "rand");
        end

        @(negedge clk);
        check("accept_count", 32'(n_acc), 32'(exp_acc));
        check("result_count", 32'(n_res), 32'(exp_res));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
